// File: rtl/rv_g_regfile_pkg.sv
// Shared types and helpers for the multi-write-port integer/FP register file.
// Addresses are unified: bit 5 selects the FP bank.
package rv_g_regfile_pkg;

    typedef logic [5:0] reg_addr_t;

    localparam int FP_BIT   = 5;
    localparam int NUM_REGS = 64;
    localparam int BOX_W    = 128;

    function automatic logic is_fp(input reg_addr_t addr);
        return addr[FP_BIT];
    endfunction

    // Bits [maxlen-1:flen] become ones so a narrow FP value reads back NaN-boxed.
    function automatic logic [BOX_W-1:0] nanbox(input logic [BOX_W-1:0] data,
                                                 input int flen, input int maxlen);
        logic [BOX_W-1:0] res;
        res = '0;
        for (int i = 0; i < BOX_W; i++) begin
            if (i < flen) res[i] = data[i];
            else          res[i] = (i < maxlen);
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_g_regfile_mp_pending_cnt.sv
// Per-register outstanding-write counters: several write-back decrements,
// one issue increment and a global flush, with a registered any-pending flag.
module rv_g_pending_cnt
    import rv_g_regfile_pkg::*;
#(
    parameter int NUM_WR      = 2,
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                           clk_i,
    input  logic                           arst_ni,
    input  logic [NUM_WR-1:0]              dec_en_i,
    input  logic [NUM_WR-1:0][5:0]         dec_addr_i,
    input  logic                           inc_en_i,
    input  logic [5:0]                     inc_addr_i,
    input  logic                           flush_i,
    output logic [NUM_REGS-1:0][CNT_W-1:0] cnt_o,
    output logic                           any_pending_o
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic                           busy_d, busy_q;

    // Decrements saturate at zero before the increment is applied, so a
    // write-back and a new lock of the same register in one cycle net out.
    always_comb begin
        int dec;
        int nxt;
        dec    = 0;
        nxt    = 0;
        cnt_d  = cnt_q;
        busy_d = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            dec = 0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (dec_en_i[p] && dec_addr_i[p] == reg_addr_t'(a)) dec++;
            end
            nxt = (int'(cnt_q[a]) > dec) ? int'(cnt_q[a]) - dec : 0;
            if (inc_en_i && inc_addr_i == reg_addr_t'(a)) nxt++;
            if (nxt > MAX_PENDING) nxt = MAX_PENDING;
            if (flush_i || a == 0) nxt = 0;
            cnt_d[a] = CNT_W'(nxt);
            busy_d   = busy_d | (nxt != 0);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign any_pending_o = busy_q;

endmodule

// File: rtl/rv_g_regfile_mp.sv
// Unified x/f register file with multiple write-back ports, per-register
// pending counters, same-cycle forwarding and NaN-boxed FP reads.
module rv_g_regfile_mp
    import rv_g_regfile_pkg::*;
#(
    parameter int  XLEN             = 64,
    parameter int  FLEN             = 32,
    parameter int  NUM_WR           = 2,
    parameter int  NUM_RS           = 3,
    parameter int  MAX_PENDING      = 3,
    parameter bit  ALLOW_FORWARDING = 1'b1,
    parameter bit  NANBOX           = 1'b1,
    localparam int MaxLen           = (XLEN > FLEN) ? XLEN : FLEN
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_WR-1:0]             wr_en_i,
    input  logic [NUM_WR-1:0][5:0]        wr_addr_i,
    input  logic [NUM_WR-1:0][MaxLen-1:0] wr_data_i,
    input  logic [5:0]                    rd_addr_i,
    input  logic [NUM_RS-1:0][5:0]        rs_addr_i,
    input  logic                          req_i,
    input  logic                          flush_i,
    output logic [NUM_RS-1:0][MaxLen-1:0] rs_data_o,
    output logic                          gnt_o,
    output logic                          busy_o
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [31:0][XLEN-1:0]          int_rf_d, int_rf_q;
    logic [31:0][FLEN-1:0]          fp_rf_d, fp_rf_q;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic                           gnt;
    logic                           inc_en;

    // Ports are applied from highest index down so the lowest index wins a collision.
    always_comb begin
        int_rf_d = int_rf_q;
        fp_rf_d  = fp_rf_q;
        for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en_i[p]) begin
                if (is_fp(wr_addr_i[p])) begin
                    fp_rf_d[wr_addr_i[p][4:0]] = wr_data_i[p][FLEN-1:0];
                end else if (wr_addr_i[p] != '0) begin
                    int_rf_d[wr_addr_i[p][4:0]] = wr_data_i[p][XLEN-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            int_rf_q <= '0;
            fp_rf_q  <= '0;
        end else begin
            int_rf_q <= int_rf_d;
            fp_rf_q  <= fp_rf_d;
        end
    end

    assign inc_en = req_i & gnt & (rd_addr_i != '0);

    rv_g_pending_cnt #(
        .NUM_WR      (NUM_WR),
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) u_pending_cnt (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .dec_en_i      (wr_en_i),
        .dec_addr_i    (wr_addr_i),
        .inc_en_i      (inc_en),
        .inc_addr_i    (rd_addr_i),
        .flush_i       (flush_i),
        .cnt_o         (cnt),
        .any_pending_o (busy_o)
    );

    // A source whose last outstanding write lands this cycle is served from the write port.
    always_comb begin
        reg_addr_t         a;
        int                c;
        logic              hit;
        logic              use_fwd;
        logic [MaxLen-1:0] fwd;
        logic [MaxLen-1:0] val;
        logic              ready;
        logic              all_ready;
        a         = '0;
        c         = 0;
        hit       = 1'b0;
        use_fwd   = 1'b0;
        fwd       = '0;
        val       = '0;
        ready     = 1'b1;
        all_ready = 1'b1;
        rs_data_o = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            a   = rs_addr_i[i];
            c   = int'(cnt[a]);
            hit = 1'b0;
            fwd = '0;
            for (int p = NUM_WR - 1; p >= 0; p--) begin
                if (wr_en_i[p] && wr_addr_i[p] == a) begin
                    hit = 1'b1;
                    fwd = wr_data_i[p];
                end
            end
            use_fwd = ALLOW_FORWARDING && hit && (c == 1);
            ready   = (c == 0) || use_fwd;
            val     = '0;
            if (is_fp(a)) begin
                val[FLEN-1:0] = use_fwd ? fwd[FLEN-1:0] : fp_rf_q[a[4:0]];
                if (NANBOX && FLEN < MaxLen) val = MaxLen'(nanbox(BOX_W'(val), FLEN, MaxLen));
            end else if (i >= 2) begin
                ready = 1'b1;
            end else if (a != '0) begin
                val[XLEN-1:0] = use_fwd ? fwd[XLEN-1:0] : int_rf_q[a[4:0]];
            end
            rs_data_o[i] = val;
            all_ready    = all_ready & ready;
        end
        gnt = req_i && !flush_i && all_ready && (int'(cnt[rd_addr_i]) < MAX_PENDING);
    end

    assign gnt_o = gnt;

endmodule

// File: tb/tb_rv_g_regfile_mp.sv
// Self-checking bench for rv_g_regfile_mp: directed scenarios plus random
// traffic compared against an array-based model of the register file.
module tb_rv_g_regfile_mp;

    logic                 clk_i = 1'b0;
    logic                 arst_ni;
    logic [1:0]           wr_en_i;
    logic [1:0][5:0]      wr_addr_i;
    logic [1:0][63:0]     wr_data_i;
    logic [5:0]           rd_addr_i;
    logic [2:0][5:0]      rs_addr_i;
    logic                 req_i;
    logic                 flush_i;
    logic [2:0][63:0]     rs_data_o;
    logic                 gnt_o;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_int [32];
    logic [31:0] m_fp  [32];
    int          m_cnt [64];

    rv_g_regfile_mp dut (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_i),
        .rs_addr_i (rs_addr_i),
        .req_i     (req_i),
        .flush_i   (flush_i),
        .rs_data_o (rs_data_o),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_int[i] = '0;
            m_fp[i]  = '0;
        end
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    endfunction

    function automatic int m_fwd_port(logic [5:0] a);
        for (int p = 0; p < 2; p++) begin
            if (wr_en_i[p] && wr_addr_i[p] == a) return p;
        end
        return -1;
    endfunction

    function automatic bit m_ready(int port, logic [5:0] a);
        if (!a[5] && port >= 2) return 1'b1;
        return (m_cnt[a] == 0) || (m_cnt[a] == 1 && m_fwd_port(a) >= 0);
    endfunction

    function automatic logic [63:0] m_read(int port, logic [5:0] a);
        int  fp;
        bit  fwd;
        fp  = m_fwd_port(a);
        fwd = (fp >= 0) && (m_cnt[a] == 1);
        if (a[5]) return {32'hFFFF_FFFF, fwd ? wr_data_i[fp][31:0] : m_fp[a[4:0]]};
        if (port >= 2 || a == 6'd0) return 64'd0;
        return fwd ? wr_data_i[fp] : m_int[a[4:0]];
    endfunction

    function automatic bit m_gnt();
        if (!req_i || flush_i) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!m_ready(i, rs_addr_i[i])) return 1'b0;
        end
        return m_cnt[rd_addr_i] < 3;
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < 64; i++) begin
            if (m_cnt[i] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [5:0] rnd_addr();
        return {1'($urandom_range(0, 1)), 2'b00, 3'($urandom_range(0, 7))};
    endfunction

    task automatic set_idle();
        wr_en_i   = '0;
        wr_addr_i = '0;
        wr_data_i = '0;
        rd_addr_i = '0;
        rs_addr_i = '0;
        req_i     = 1'b0;
        flush_i   = 1'b0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit g;
        int dec [64];
        g = m_gnt();
        @(posedge clk_i);
        for (int a = 0; a < 64; a++) dec[a] = 0;
        for (int p = 0; p < 2; p++) begin
            if (wr_en_i[p]) begin
                dec[wr_addr_i[p]]++;
                if (m_fwd_port(wr_addr_i[p]) == p) begin
                    if (wr_addr_i[p][5]) m_fp[wr_addr_i[p][4:0]] = wr_data_i[p][31:0];
                    else if (wr_addr_i[p] != 6'd0) m_int[wr_addr_i[p][4:0]] = wr_data_i[p];
                end
            end
        end
        for (int a = 0; a < 64; a++) begin
            int n;
            n = m_cnt[a] - dec[a];
            if (n < 0) n = 0;
            if (g && rd_addr_i == 6'(a) && a != 0) n++;
            m_cnt[a] = flush_i ? 0 : n;
        end
        #1;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        set_idle();
        rs_addr_i[0] = 6'd5;
        rs_addr_i[1] = 6'h23;
        m_reset();
        #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got=%0b exp=0", gnt_o); end
        checks++; if (rs_data_o[0] !== 64'd0) begin errors++; $display("[TB] FAIL reset_x5 got=%h exp=0", rs_data_o[0]); end
        checks++; if (rs_data_o[1] !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("[TB] FAIL reset_f3 got=%h exp=ffffffff00000000", rs_data_o[1]); end
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk_i); set_idle();
        wr_en_i[0] = 1'b1; wr_addr_i[0] = 6'd5; wr_data_i[0] = 64'hDEAD_BEEF;
        #1; tick();
        @(negedge clk_i); set_idle();
        rs_addr_i[0] = 6'd5; rs_addr_i[1] = 6'h23;
        #1;
        checks++; if (rs_data_o[0] !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("[TB] FAIL basic_x5 got=%h exp=deadbeef", rs_data_o[0]); end
        checks++; if (rs_data_o[1] !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("[TB] FAIL basic_f3 got=%h exp=ffffffff00000000", rs_data_o[1]); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); set_idle();
            req_i = 1'b1; rd_addr_i = 6'd7;
            #1;
            checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL waw_lock%0d got=%0b exp=1", k, gnt_o); end
            tick();
        end
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rd_addr_i = 6'd7;
        #1;
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL waw_full got=%0b exp=0", gnt_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL waw_busy got=%0b exp=1", busy_o); end
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i); set_idle();
            req_i = 1'b1; rs_addr_i[0] = 6'd7;
            wr_en_i[0] = 1'b1; wr_addr_i[0] = 6'd7; wr_data_i[0] = 64'h100 + 64'(k);
            #1;
            checks++; if (gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL waw_wait%0d got=%0b exp=0", k, gnt_o); end
            tick();
        end
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rs_addr_i[0] = 6'd7;
        wr_en_i[1] = 1'b1; wr_addr_i[1] = 6'd7; wr_data_i[1] = 64'hCAFE_0003;
        #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL waw_fwd_gnt got=%0b exp=1", gnt_o); end
        checks++; if (rs_data_o[0] !== 64'hCAFE_0003) begin errors++; $display("[TB] FAIL waw_fwd_data got=%h exp=cafe0003", rs_data_o[0]); end
        tick();
        @(negedge clk_i); set_idle();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL waw_idle got=%0b exp=0", busy_o); end
    endtask

    task automatic test_forward();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rd_addr_i = 6'h22;
        #1; tick();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rs_addr_i[0] = 6'h22;
        wr_en_i[1] = 1'b1; wr_addr_i[1] = 6'h22; wr_data_i[1] = 64'h3F80_0000;
        #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL fwd_gnt got=%0b exp=1", gnt_o); end
        checks++; if (rs_data_o[0] !== 64'hFFFF_FFFF_3F80_0000) begin errors++; $display("[TB] FAIL fwd_f2 got=%h exp=ffffffff3f800000", rs_data_o[0]); end
        tick();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rd_addr_i = 6'd9;
        #1; tick();
        @(negedge clk_i); set_idle();
        wr_en_i = 2'b11; wr_addr_i[0] = 6'd9; wr_addr_i[1] = 6'd9;
        wr_data_i[0] = 64'h11; wr_data_i[1] = 64'h22;
        #1; tick();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rs_addr_i[0] = 6'd9;
        #1;
        checks++; if (rs_data_o[0] !== 64'h11) begin errors++; $display("[TB] FAIL collide_x9 got=%h exp=11", rs_data_o[0]); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL collide_gnt got=%0b exp=1", gnt_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL collide_busy got=%0b exp=0", busy_o); end
        tick();
    endtask

    task automatic test_x0();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rd_addr_i = 6'd0;
        #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL x0_gnt got=%0b exp=1", gnt_o); end
        tick();
        @(negedge clk_i); set_idle();
        wr_en_i = 2'b11; wr_addr_i[0] = 6'd0; wr_data_i[0] = 64'h55;
        wr_addr_i[1] = 6'd4; wr_data_i[1] = 64'h1234;
        #1; tick();
        @(negedge clk_i); set_idle();
        rs_addr_i[0] = 6'd0; rs_addr_i[1] = 6'd4; rs_addr_i[2] = 6'd4;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL x0_busy got=%0b exp=0", busy_o); end
        checks++; if (rs_data_o[0] !== 64'd0) begin errors++; $display("[TB] FAIL x0_read got=%h exp=0", rs_data_o[0]); end
        checks++; if (rs_data_o[1] !== 64'h1234) begin errors++; $display("[TB] FAIL x4_read got=%h exp=1234", rs_data_o[1]); end
        checks++; if (rs_data_o[2] !== 64'd0) begin errors++; $display("[TB] FAIL rs2_int got=%h exp=0", rs_data_o[2]); end
    endtask

    task automatic test_flush();
        logic [5:0] locks [3];
        locks[0] = 6'd1; locks[1] = 6'd2; locks[2] = 6'h21;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); set_idle();
            req_i = 1'b1; rd_addr_i = locks[k];
            #1; tick();
        end
        @(negedge clk_i); set_idle();
        flush_i = 1'b1; req_i = 1'b1; rd_addr_i = 6'd3;
        wr_en_i[0] = 1'b1; wr_addr_i[0] = 6'd1; wr_data_i[0] = 64'hAA;
        #1;
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_gnt got=%0b exp=0", gnt_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_prebusy got=%0b exp=1", busy_o); end
        tick();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rs_addr_i[0] = 6'd1; rs_addr_i[1] = 6'd2; rs_addr_i[2] = 6'h21;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got=%0b exp=0", busy_o); end
        checks++; if (rs_data_o[0] !== 64'hAA) begin errors++; $display("[TB] FAIL flush_x1 got=%h exp=aa", rs_data_o[0]); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_after_gnt got=%0b exp=1", gnt_o); end
        tick();
    endtask

    task automatic test_async_reset();
        @(negedge clk_i); set_idle();
        wr_en_i[0] = 1'b1; wr_addr_i[0] = 6'd3; wr_data_i[0] = 64'h77;
        #1; tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i); set_idle();
            req_i = 1'b1; rd_addr_i = 6'd3;
            #1; tick();
        end
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rs_addr_i[0] = 6'd3;
        #1;
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_pre_gnt got=%0b exp=0", gnt_o); end
        #2;
        arst_ni = 1'b0;
        m_reset();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy got=%0b exp=0", busy_o); end
        checks++; if (rs_data_o[0] !== 64'd0) begin errors++; $display("[TB] FAIL arst_x3 got=%h exp=0", rs_data_o[0]); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL arst_gnt got=%0b exp=1", gnt_o); end
        @(negedge clk_i);
        arst_ni = 1'b1; set_idle();
        wr_en_i[0] = 1'b1; wr_addr_i[0] = 6'd3; wr_data_i[0] = 64'h99;
        #1; tick();
        @(negedge clk_i); set_idle();
        req_i = 1'b1; rs_addr_i[0] = 6'd3;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL late_busy got=%0b exp=0", busy_o); end
        checks++; if (rs_data_o[0] !== 64'h99) begin errors++; $display("[TB] FAIL late_x3 got=%h exp=99", rs_data_o[0]); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL late_gnt got=%0b exp=1", gnt_o); end
        tick();
    endtask

    task automatic test_random();
        logic [63:0] exp_d;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i); set_idle();
            for (int p = 0; p < 2; p++) begin
                wr_en_i[p]   = ($urandom_range(0, 2) == 0);
                wr_addr_i[p] = rnd_addr();
                wr_data_i[p] = {$urandom, $urandom};
            end
            req_i        = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 19) == 0);
            rd_addr_i    = rnd_addr();
            rs_addr_i[0] = rnd_addr();
            rs_addr_i[1] = rnd_addr();
            rs_addr_i[2] = rnd_addr() | 6'h20;
            #1;
            checks++; if (gnt_o !== m_gnt()) begin errors++; $display("[TB] FAIL rand_gnt cyc=%0d got=%0b exp=%0b", n, gnt_o, m_gnt()); end
            for (int i = 0; i < 3; i++) begin
                exp_d = m_read(i, rs_addr_i[i]);
                checks++; if (rs_data_o[i] !== exp_d) begin errors++; $display("[TB] FAIL rand_rs%0d cyc=%0d addr=%h got=%h exp=%h", i, n, rs_addr_i[i], rs_data_o[i], exp_d); end
            end
            checks++; if (busy_o !== m_busy()) begin errors++; $display("[TB] FAIL rand_busy cyc=%0d got=%0b exp=%0b", n, busy_o, m_busy()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waw();
        test_forward();
        test_x0();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_g_regfile_mp.md
Name: rv_g_regfile_mp

Overview:
Multi-write-port successor of the integer/FP register file with its source-readiness scoreboard. It sits between decode/issue and the execute/write-back stages. The block stores the unified 64-entry register space: x0–x31 with addr[5]=0 and f0–f31 with addr[5]=1. A per-register pending counter replaces the single lock bit, so a destination can have multiple outstanding writes (WAW). It adds parameterised write-back ports, parameterised source ports, forwarding from any write port, NaN-boxing of narrow FP reads, and a pipeline flush.

Parameters:
XLEN, 64, integer register width
FLEN, 32, FP register width
MaxLen (localparam), max(XLEN,FLEN), data port width
NUM_WR, 2, write-back ports (1..4)
NUM_RS, 3, source read ports (1..4); ports with index >=2 read FP only
MAX_PENDING, 3, max outstanding writes per register (1..7)
ALLOW_FORWARDING, 1, bypass write data to sources in the same cycle
NANBOX, 1, set FP read bits [MaxLen-1:FLEN] to 1 when FLEN<MaxLen

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
wr_en_i  in  NUM_WR  per-port write and unlock enable
wr_addr_i  in  NUM_WR x 6  write address
wr_data_i  in  NUM_WR x MaxLen  write data
rd_addr_i  in  6  destination to lock on grant
rs_addr_i  in  NUM_RS x 6  source addresses
req_i  in  1  issue request
flush_i  in  1  clear all pending counts
rs_data_o  out  NUM_RS x MaxLen  source data (combinational)
gnt_o  out  1  issue grant (combinational)
busy_o  out  1  any pending counter nonzero (registered)

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_ni is asynchronous, active-low.
- Reset values: all registers 0, all counters 0, busy_o=0. gnt_o=0 while req_i=0.
- Reset-time reads: rs_data_o returns stored values. An FP read after reset is 0 in bits [FLEN-1:0] and all 1s above if NANBOX.
- Writes:
  - A write commits at the posedge when wr_en_i[p] is set.
  - Integer writes take wr_data_i[XLEN-1:0]; writes to x0 are dropped.
  - FP writes take wr_data_i[FLEN-1:0].
  - If two ports write the same address in one cycle, the lowest port index wins the data.
- Pending counter cnt[a], 0..MAX_PENDING:
  - dec = number of enabled ports writing a this cycle.
  - inc = 1 if (req_i & gnt_o & rd_addr_i==a & a!=0).
  - next = sat0(cnt - dec) + inc.
  - Decrement below 0 saturates at 0 (no error).
  - x0 counter is always 0.
- Source ready:
  - Ready if cnt==0.
  - If ALLOW_FORWARDING, also ready when cnt==1 and any enabled write port targets it this cycle.
  - cnt>=2 means not ready.
- Source data:
  - If forwarding applies, data comes from the matching write port (lowest index).
  - Otherwise data comes from the register file.
  - Integer addresses on port index >=2 return 0.
  - x0 always returns 0.
  - FP data is NaN-boxed per NANBOX.
- Destination ready: cnt[rd_addr_i] < MAX_PENDING, evaluated on the current count before same-cycle decrements.
- Grant:
  - gnt_o = req_i & ~flush_i & all NUM_RS sources ready & destination ready.
  - Sources are always checked; issue logic must tie unused rs to 0.
- Flush: all counters go to 0 at the next edge, overriding inc/dec. Writes in the flush cycle still commit data.
- busy_o: registered OR of next-state counters, so it goes low the cycle after the last unlock or flush.
- Reset mid-operation: all state clears immediately. Outstanding writes arriving after reset still commit data, and decrement saturates at 0.

Decomposition:
- rv_g_regfile_pkg:
  - typedef reg_addr_t (6 bits).
  - FP_BIT=5.
  - function is_fp(addr).
  - function nanbox(data) parameterised by FLEN/MaxLen.
- One sub-module, rv_g_pending_cnt: a 64-entry saturating counter array with NUM_WR decrement ports, one increment port and flush. It outputs cnt per entry and any_pending.
- Storage stays inline: two arrays (integer, FP) with NUM_WR write ports.

Test Plan:
- Basic write/read: after reset, write x5=64'hDEAD_BEEF on port0, then read rs0=x5 and rs1=f3. Expect rs0=0xDEADBEEF; rs1=0xFFFFFFFF_00000000 (NANBOX=1, FLEN=32); busy_o=0.
- WAW pending: req rd=x7 granted three times, giving cnt=3. A fourth req with rd=x7 gives gnt_o=0. A read of x7 is not ready until two writes arrive. The third write forwards with gnt_o=1 that cycle.
- Forwarding and collisions: cnt[f2]=1, port1 writes f2=0x3F800000 while req has rs0=f2. Expect gnt_o=1 and rs0=0xFFFFFFFF_3F800000. Ports 0 and 1 both write x9 (0x11, 0x22) in the same cycle. Expect x9=0x11 and cnt decremented by 2, saturating at 0.
- x0 rules: req with rd=x0 is granted and does not change cnt. A write of 0x55 to x0 then reads 0. Integer rs2=x4 reads 0 on port index 2.
- Flush: lock x1, x2, f1, then assert flush_i together with req_i and a write to x1=0xAA. Expect gnt_o=0. Next cycle all counters are 0, busy_o=0 and x1=0xAA.
- Async reset mid-operation: with cnt[x3]=2, drop arst_ni mid-cycle. Expect counters, registers and busy_o cleared without a clock edge. A subsequent write to x3 commits and the counter stays 0.
